// File: rtl/bounce_generator_pkg.sv
// Shared definitions for the bounce generator: FSM state encoding, LFSR
// feedback mask, default seed and the fixup applied to an all-zero seed.
package bounce_generator_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBounce = 2'd1,
    StSettle = 2'd2
  } state_e;

  // Galois feedback taps for the 8-bit LFSR
  localparam logic [7:0] LfsrMask    = 8'hB8;
  localparam logic [7:0] DefaultSeed = 8'hA5;
  // An all-zero LFSR never leaves zero, so a zero seed is replaced by this
  localparam logic [7:0] SeedFixup   = 8'h01;

  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? SeedFixup : seed;
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr8.sv
// Free-running 8-bit Galois LFSR used to randomise glitch spacing.
// Ports:
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset (loads the seed)
//   o_lfsr  - current LFSR state
module bounce_generator_lfsr8
  import bounce_generator_pkg::*;
#(
  parameter logic [7:0] SEED = DefaultSeed
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_lfsr
);

  localparam logic [7:0] SeedEff = fix_seed(SEED);

  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;

  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LfsrMask : 8'h00);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SeedEff;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/bounce_generator.sv
// Bounce generator: turns a clean level command into a deterministic bouncy
// button waveform (first edge, 2*BOUNCE_COUNT glitch toggles, settled hold).
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset
//   cmd   - clean requested button level
//   out   - bouncy button waveform (registered)
//   busy  - high while a sequence is in progress
//   done  - one-cycle pulse when a sequence finishes settling
module bounce_generator
  import bounce_generator_pkg::*;
#(
  parameter int unsigned            CLOCK_SIZE   = 9,
  parameter int unsigned            BOUNCE_COUNT = 4,
  parameter logic [CLOCK_SIZE-1:0]  GAP_MIN      = 9'd8,
  parameter logic [7:0]             GAP_MASK     = 8'h1F,
  parameter logic [CLOCK_SIZE-1:0]  SETTLE_LIMIT = 9'd400,
  parameter logic [7:0]             SEED         = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  input  logic cmd,
  output logic out,
  output logic busy,
  output logic done
);

  // Sized so that 2*BOUNCE_COUNT fits, with at least one bit when it is 0
  localparam int unsigned ToggleW = $clog2(2 * BOUNCE_COUNT + 2);
  localparam logic [ToggleW-1:0]    ToggleInit = ToggleW'(2 * BOUNCE_COUNT);
  localparam logic [ToggleW-1:0]    ToggleOne  = ToggleW'(1);
  localparam logic [CLOCK_SIZE-1:0] CntOne     = CLOCK_SIZE'(1);

  logic [7:0]            w_lfsr;
  logic [CLOCK_SIZE-1:0] w_gap;

  state_e                r_state, w_state_next;
  logic                  r_cmd;
  logic                  r_out, w_out_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic                  r_level, w_level_next;
  logic                  r_target, w_target_next;
  logic [ToggleW-1:0]    r_toggles, w_toggles_next;
  logic [CLOCK_SIZE-1:0] r_gap_cnt, w_gap_cnt_next;
  logic [CLOCK_SIZE-1:0] r_settle_cnt, w_settle_cnt_next;

  bounce_generator_lfsr8 #(
    .SEED (SEED)
  ) u_lfsr8 (
    .i_clk   (clock),
    .i_rst_n (reset),
    .o_lfsr  (w_lfsr)
  );

  assign w_gap = GAP_MIN + CLOCK_SIZE'(w_lfsr & GAP_MASK);

  always_comb begin
    w_state_next      = r_state;
    w_out_next        = r_out;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;
    w_level_next      = r_level;
    w_target_next     = r_target;
    w_toggles_next    = r_toggles;
    w_gap_cnt_next    = r_gap_cnt;
    w_settle_cnt_next = r_settle_cnt;

    unique case (r_state)
      StIdle: begin
        // r_cmd is the command registered one edge earlier
        if (r_cmd != r_level) begin
          w_out_next     = r_cmd;
          w_target_next  = r_cmd;
          w_toggles_next = ToggleInit;
          w_gap_cnt_next = w_gap;
          w_busy_next    = 1'b1;
          w_state_next   = StBounce;
        end
      end
      StBounce: begin
        if (r_gap_cnt != '0) begin
          w_gap_cnt_next = r_gap_cnt - CntOne;
        end else if (r_toggles != '0) begin
          w_out_next     = ~r_out;
          w_toggles_next = r_toggles - ToggleOne;
          w_gap_cnt_next = w_gap;
        end else begin
          // Even number of toggles, so out already equals target here
          w_settle_cnt_next = '0;
          w_state_next      = StSettle;
        end
      end
      StSettle: begin
        if (r_settle_cnt == SETTLE_LIMIT) begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_level_next = r_target;
          w_state_next = StIdle;
        end else begin
          w_settle_cnt_next = r_settle_cnt + CntOne;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_cmd        <= 1'b0;
      r_out        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_level      <= 1'b0;
      r_target     <= 1'b0;
      r_toggles    <= '0;
      r_gap_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cmd        <= cmd;
      r_out        <= w_out_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_level      <= w_level_next;
      r_target     <= w_target_next;
      r_toggles    <= w_toggles_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_settle_cnt <= w_settle_cnt_next;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench: dut_a uses a deterministic config (no random gap) for exact
// edge timing; dut_b uses the random-gap config for edge count, spacing range
// and run-to-run reproducibility.
module tb_bounce_generator;

  logic clock;
  logic reset;
  logic cmd_a, out_a, busy_a, done_a;
  logic cmd_b, out_b, busy_b, done_b;

  int checks;
  int errors;

  bounce_generator #(
    .CLOCK_SIZE   (9),
    .BOUNCE_COUNT (2),
    .GAP_MIN      (9'd3),
    .GAP_MASK     (8'h00),
    .SETTLE_LIMIT (9'd10),
    .SEED         (8'hA5)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .cmd   (cmd_a),
    .out   (out_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  bounce_generator #(
    .CLOCK_SIZE   (9),
    .BOUNCE_COUNT (4),
    .GAP_MIN      (9'd8),
    .GAP_MASK     (8'h1F),
    .SETTLE_LIMIT (9'd20),
    .SEED         (8'hA5)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .cmd   (cmd_b),
    .out   (out_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected out j edges after the first edge of a rising sequence
  // (gap 3 -> edges every 4 cycles at j = 1, 5, 9, 13, 17).
  function automatic logic exp_rise(input int j);
    if (j <= 4) return 1'b1;
    else if (j <= 8) return 1'b0;
    else if (j <= 12) return 1'b1;
    else if (j <= 16) return 1'b0;
    else return 1'b1;
  endfunction

  int  st[2][16];
  int  ne[2];
  int  sp;
  int  jj;
  logic inv;
  logic prev;
  logic seen;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    cmd_a  = 1'b0;
    cmd_b  = 1'b0;

    // Reset held with cmd toggling: everything stays quiet
    for (int i = 0; i < 6; i++) begin
      cmd_a = ~cmd_a;
      cmd_b = ~cmd_a;
      tick();
      chk("rst_out_a", out_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_out_b", out_b, 0);
    end
    cmd_a = 1'b0;
    cmd_b = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_out_a", out_a, 0);
      chk("idle_busy_a", busy_a, 0);
      chk("idle_done_a", done_a, 0);
      chk("idle_out_b", out_b, 0);
      chk("idle_busy_b", busy_b, 0);
    end

    // Rising sequence, then cmd back to 0 mid-sequence (deferred second run)
    cmd_a = 1'b1;
    tick();  // E0: cmd captured, no output change yet
    chk("e0_out", out_a, 0);
    chk("e0_busy", busy_a, 0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      jj  = (k <= 32) ? k : k - 32;
      inv = (k > 32);
      chk("seq_out", out_a, exp_rise(jj) ^ inv);
      chk("seq_busy", busy_a, (jj == 32) ? 0 : 1);
      chk("seq_done", done_a, (jj == 32) ? 1 : 0);
      if (k == 9) cmd_a = 1'b0;
    end
    tick();
    chk("after_out", out_a, 0);
    chk("after_busy", busy_a, 0);
    chk("after_done", done_a, 0);

    // Reset mid-sequence at E12
    cmd_a = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("pre_rst_out", out_a, exp_rise(k));
      chk("pre_rst_busy", busy_a, 1);
    end
    reset = 1'b0;
    #1;
    chk("async_rst_out", out_a, 0);
    chk("async_rst_busy", busy_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_rst_out", out_a, 0);
      chk("held_rst_done", done_a, 0);
    end
    reset = 1'b1;
    tick();
    chk("restart_e0_out", out_a, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("restart_out", out_a, exp_rise(k));
      chk("restart_busy", busy_a, (k == 32) ? 0 : 1);
      chk("restart_done", done_a, (k == 32) ? 1 : 0);
    end
    tick();
    chk("restart_idle_out", out_a, 1);
    chk("restart_idle_done", done_a, 0);

    // Random-gap sequences: two identical runs from reset
    cmd_a = 1'b0;
    for (int r = 0; r < 2; r++) begin
      reset = 1'b0;
      cmd_b = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      tick();
      cmd_b = 1'b1;
      prev  = out_b;
      seen  = 1'b0;
      ne[r] = 0;
      for (int c = 1; c <= 1000 && !seen; c++) begin
        tick();
        if (out_b !== prev) begin
          if (ne[r] < 16) st[r][ne[r]] = c;
          ne[r]++;
          prev = out_b;
        end
        if (done_b === 1'b1) seen = 1'b1;
      end
      chk("b_done_seen", seen, 1);
      chk("b_edge_count", ne[r], 9);
      chk("b_first_edge", st[r][0], 2);
      chk("b_final_out", out_b, 1);
      for (int i = 1; i < ne[r] && i < 9; i++) begin
        sp = st[r][i] - st[r][i-1];
        chk("b_spacing_in_range", (sp >= 9 && sp <= 40) ? 1 : 0, 1);
      end
    end
    for (int i = 0; i < 9; i++) begin
      chk("b_repro", st[1][i], st[0][i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
